half_word_serializer: RTL

//   Downstream stage of the 16-bit half-word datapath. Accepts 16-bit words over
//   a valid/ready handshake, buffers them in a small word FIFO, and emits each

---
 rtl/half_word_serializer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/half_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : half_word_serializer
// Purpose  : Buffers 16-bit words from a valid/ready producer in a small
//            FIFO and emits each word as two bytes on a byte-wide
//            valid/ready stream. out_last flags the second byte of a word.
// Ports    : clk, rst_n               - clock, async active-low reset
//            in_word/in_valid/in_ready - word input handshake
//            out_byte/out_valid/out_ready/out_last - byte output stream
//            fifo_level               - words held (incl. one partly sent)
//            word_count               - completed words since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module half_word_serializer #(
  parameter int HI_FIRST   = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   in_word,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [7:0]                    out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   word_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic [15:0]   word_count_q, word_count_d;

  logic [LW-1:0] level;
  logic          push;
  logic          pop;
  logic [15:0]   head;
  logic [7:0]    first_byte;
  logic [7:0]    second_byte;

  // Pointers carry one extra MSB so full (difference == depth) and empty
  // (difference == 0) are distinct.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign in_ready = (level != LW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == ST_SECOND) && out_ready;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  if (HI_FIRST != 0) begin : g_hi_first
    assign first_byte  = head[15:8];
    assign second_byte = head[7:0];
  end else begin : g_lo_first
    assign first_byte  = head[7:0];
    assign second_byte = head[15:8];
  end

  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = in_word;
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    word_count_d = word_count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + LW'(1);
    end
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + LW'(1);
      word_count_d = word_count_q + 16'd1;
    end
  end

  // Next-state logic. After a pop, stay busy if another word was already
  // buffered or one is being pushed in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_FIRST;
      end
      ST_FIRST: begin
        if (out_ready) state_d = ST_SECOND;
      end
      ST_SECOND: begin
        if (out_ready) begin
          state_d = ((level > LW'(1)) || push) ? ST_FIRST : ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Outputs depend on registered state only.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_byte  = 8'h00;
    case (state_q)
      ST_FIRST: begin
        out_valid = 1'b1;
        out_byte  = first_byte;
      end
      ST_SECOND: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_byte  = second_byte;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      word_count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      word_count_q <= word_count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign fifo_level = level;
  assign word_count = word_count_q;

endmodule
`default_nettype wire
